clock_time_keeper: RTL

CLOCK_TIME_KEEPER -- requirements
Module: clock_time_keeper

---
 rtl/clock_time_keeper.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/clock_time_keeper.sv
// HH:MM:SS BCD time keeper with a RUN / SET_HOUR / SET_MIN set-mode FSM.
// Blinking enable on the field being edited.
module clock_time_keeper #(
    parameter int CLK_HZ    = 50000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mode_i,
    input  logic       inc_i,
    output logic [3:0] hour_t_o,
    output logic [3:0] hour_u_o,
    output logic [3:0] min_t_o,
    output logic [3:0] min_u_o,
    output logic [3:0] sec_t_o,
    output logic [3:0] sec_u_o,
    output logic       hour_on_o,
    output logic       min_on_o,
    output logic       sec_on_o,
    output logic       sec_pulse_o
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [BW-1:0] blink, blink_n;
    logic          phase, phase_n;
    logic [7:0]    hour, hour_n, min, min_n, sec, sec_n;
    logic          sec_pulse_n, hour_on_n, min_on_n;
    logic [8:0]    sec_inc, min_inc;
    logic [7:0]    hour_inc;

    // {carry, tens, units} for a 00..59 BCD field
    function automatic logic [8:0] bcd60_inc(input logic [7:0] v);
        if (v[3:0] != 4'd9) return {1'b0, v[7:4], v[3:0] + 4'd1};
        if (v[7:4] != 4'd5) return {1'b0, v[7:4] + 4'd1, 4'd0};
        return 9'h100;
    endfunction

    function automatic logic [7:0] bcd24_inc(input logic [7:0] v);
        if (v == 8'h23) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign sec_inc  = bcd60_inc(sec);
    assign min_inc  = bcd60_inc(min);
    assign hour_inc = bcd24_inc(hour);

    always_comb begin
        state_n     = state;
        presc_n     = presc;
        hour_n      = hour;
        min_n       = min;
        sec_n       = sec;
        sec_pulse_n = 1'b0;
        blink_n     = blink;
        phase_n     = phase;
        case (state)
            RUN: begin
                if (mode_i) begin
                    state_n = SET_HOUR;
                    sec_n   = 8'h00;
                    presc_n = '0;
                end else if (presc == PRESC_MAX) begin
                    presc_n     = '0;
                    sec_pulse_n = 1'b1;
                    sec_n       = sec_inc[7:0];
                    if (sec_inc[8]) begin
                        min_n = min_inc[7:0];
                        if (min_inc[8]) hour_n = hour_inc;
                    end
                end else begin
                    presc_n = presc + PW'(1);
                end
            end
            SET_HOUR: begin
                if (mode_i)     state_n = SET_MIN;
                else if (inc_i) hour_n  = hour_inc;
            end
            SET_MIN: begin
                if (mode_i) begin
                    state_n = RUN;
                    presc_n = '0;
                end else if (inc_i) begin
                    min_n = min_inc[7:0];
                end
            end
            default: state_n = RUN;
        endcase

        // Blink restarts in the visible phase on every state change
        if (state_n != state) begin
            blink_n = '0;
            phase_n = 1'b1;
        end else if (state != RUN) begin
            if (blink == BLINK_MAX) begin
                blink_n = '0;
                phase_n = ~phase;
            end else begin
                blink_n = blink + BW'(1);
            end
        end

        hour_on_n = (state_n == SET_HOUR) ? phase_n : 1'b1;
        min_on_n  = (state_n == SET_MIN)  ? phase_n : 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= RUN;
            presc       <= '0;
            blink       <= '0;
            phase       <= 1'b1;
            hour        <= 8'h00;
            min         <= 8'h00;
            sec         <= 8'h00;
            sec_pulse_o <= 1'b0;
            hour_on_o   <= 1'b1;
            min_on_o    <= 1'b1;
            sec_on_o    <= 1'b1;
        end else begin
            state       <= state_n;
            presc       <= presc_n;
            blink       <= blink_n;
            phase       <= phase_n;
            hour        <= hour_n;
            min         <= min_n;
            sec         <= sec_n;
            sec_pulse_o <= sec_pulse_n;
            hour_on_o   <= hour_on_n;
            min_on_o    <= min_on_n;
            sec_on_o    <= 1'b1;
        end
    end

    assign hour_t_o = hour[7:4];
    assign hour_u_o = hour[3:0];
    assign min_t_o  = min[7:4];
    assign min_u_o  = min[3:0];
    assign sec_t_o  = sec[7:4];
    assign sec_u_o  = sec[3:0];

endmodule
